// File: rtl/bin_to_bcd_dd.sv
// bin_to_bcd_dd: serial double-dabble binary-to-BCD converter with start/busy/done handshake
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst_n    synchronous reset, active low
//   st       start request, accepted only while idle
//   bin_in   unsigned operand, captured on the edge that accepts st
//   BCD_out  registered packed BCD result, digit 0 in [3:0], holds the last result
//   busy     high while a conversion is in progress (adjust/shift phases)
//   done     one-cycle completion pulse, never high together with busy
module bin_to_bcd_dd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   BCD_out,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADJ   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    function automatic longint unsigned pow10(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction
    if (BIN_W < 2 || BIN_W > 32 || pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_params
        $error("bin_to_bcd_dd: BIN_W must be 2..32 and DIGITS must hold 2**BIN_W-1");
    end
    logic [1:0]          state;
    logic [BIN_W-1:0]    acc_bin;
    logic [4*DIGITS-1:0] acc_bcd;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] sh;
    logic [CW-1:0]       count;
    logic                last;
    // Each digit is corrected independently; a digit <=9 becomes <=12, so no carry is needed.
    genvar i;
    for (i = 0; i < DIGITS; i++) begin : g_adj
        assign adj[4*i +: 4] = acc_bcd[4*i +: 4] >= 4'd5 ? acc_bcd[4*i +: 4] + 4'd3 : acc_bcd[4*i +: 4];
    end
    // Binary MSB shifts into the BCD LSB.
    assign sh   = {acc_bcd[4*DIGITS-2:0], acc_bin[BIN_W-1]};
    assign last = count == CW'(BIN_W - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            BCD_out <= '0;
            acc_bin <= '0;
            acc_bcd <= '0;
            count   <= '0;
        end else begin
            case (state)
                S_IDLE: if (st) begin
                    acc_bin <= bin_in;
                    acc_bcd <= '0;
                    count   <= '0;
                    state   <= S_ADJ;
                end
                S_ADJ: begin
                    acc_bcd <= adj;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    acc_bcd <= sh;
                    acc_bin <= {acc_bin[BIN_W-2:0], 1'b0};
                    count   <= count + CW'(1);
                    state   <= last ? S_DONE : S_ADJ;
                    if (last) BCD_out <= sh;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    assign busy = state == S_ADJ || state == S_SHIFT;
    assign done = state == S_DONE;
endmodule

// File: tb/tb_bin_to_bcd_dd.sv
// tb_bin_to_bcd_dd: directed checks of bin_to_bcd_dd at 8/3 and 10/4 against a cycle-count/decimal model
module tb_bin_to_bcd_dd;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        st [2];
    logic [7:0]  bin8 = '0;
    logic [9:0]  bin10 = '0;
    logic [11:0] bcd8;
    logic [15:0] bcd10;
    logic        busy [2];
    logic        done [2];
    int          n_vec = 0;
    int          n_err = 0;

    bin_to_bcd_dd #(.BIN_W(8), .DIGITS(3)) u8 (
        .clk(clk), .rst_n(rst_n), .st(st[0]), .bin_in(bin8),
        .BCD_out(bcd8), .busy(busy[0]), .done(done[0])
    );
    bin_to_bcd_dd #(.BIN_W(10), .DIGITS(4)) u10 (
        .clk(clk), .rst_n(rst_n), .st(st[1]), .bin_in(bin10),
        .BCD_out(bcd10), .busy(busy[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    function automatic int bw(input int k);
        return k != 0 ? 10 : 8;
    endfunction

    function automatic logic [31:0] obcd(input int k);
        return k != 0 ? {16'b0, bcd10} : {20'b0, bcd8};
    endfunction

    // Decimal digits by plain division, independent of the shift-and-add method.
    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r = '0;
        int unsigned x = v;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[u%0d] got %h want %h at %0t", name, bw(k), act, exp, $time);
        end
    endtask

    // Model: an accepted operand keeps the unit busy for 2*BIN_W cycles, then one done
    // cycle presents its decimal value; start requests count only while idle.
    int              m_left [2];
    logic            m_done [2];
    logic [31:0]     m_bcd  [2];
    int unsigned     m_val  [2];
    logic            m_ok = 0;

    always @(posedge clk) begin
        if (!rst_n) m_ok <= 1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_left[k] <= 0;
                m_done[k] <= 0;
                m_bcd[k]  <= '0;
            end else if (m_left[k] > 0) begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) begin
                    m_done[k] <= 1;
                    m_bcd[k]  <= to_bcd(m_val[k]);
                end
            end else if (m_done[k]) begin
                m_done[k] <= 0;
            end else if (st[k]) begin
                m_left[k] <= 2 * bw(k);
                m_val[k]  <= k != 0 ? int'(bin10) : int'(bin8);
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            for (int k = 0; k < 2; k++) begin
                chk("busy", k, 32'(busy[k]), 32'(m_left[k] > 0));
                chk("done", k, 32'(done[k]), 32'(m_done[k]));
                chk("bcd", k, obcd(k), m_bcd[k]);
            end
        end
    end

    task automatic run(input int k, input int unsigned v, input logic [31:0] exp);
        int i;
        @(negedge clk);
        if (k != 0) bin10 = v[9:0];
        else bin8 = v[7:0];
        st[k] = 1;
        for (i = 1; i <= 60; i++) begin
            @(negedge clk);
            st[k] = 0;
            if (done[k]) break;
        end
        chk("latency", k, i, 2 * bw(k) + 1);
        chk("result", k, obcd(k), exp);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int j;
        int seen;
        st[0] = 1;
        st[1] = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        st[0] = 0;
        st[1] = 0;
        chk("rst_bcd", 0, obcd(0), 32'h0);
        chk("rst_bcd", 1, obcd(1), 32'h0);
        chk("rst_busy", 0, 32'(busy[0]), 32'h0);
        chk("rst_done", 0, 32'(done[0]), 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_no_start", 0, 32'(busy[0]), 32'h0);

        run(0, 0, 32'h000);
        run(0, 255, 32'h255);
        run(0, 99, 32'h099);
        run(0, 100, 32'h100);
        run(0, 5, 32'h005);

        // st held high: back-to-back conversions, operand changed right after acceptance
        @(negedge clk);
        bin8 = 200;
        st[0] = 1;
        for (i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) bin8 = 37;
            if (done[0]) break;
        end
        chk("held_lat1", 0, i, 17);
        chk("held_res1", 0, obcd(0), 32'h200);
        for (j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (j == 3) st[0] = 0;
            if (j == 4) st[0] = 1;
            if (done[0]) break;
        end
        st[0] = 0;
        chk("held_gap", 0, j, 18);
        chk("held_res2", 0, obcd(0), 32'h037);

        // abort a conversion of 173 with reset at its seventh cycle
        @(negedge clk);
        bin8 = 173;
        st[0] = 1;
        repeat (7) begin
            @(negedge clk);
            st[0] = 0;
        end
        rst_n = 0;
        st[0] = 1;
        @(negedge clk);
        rst_n = 1;
        st[0] = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done[0]) seen++;
        end
        chk("abort_no_done", 0, seen, 0);
        chk("abort_bcd", 0, obcd(0), 32'h0);
        run(0, 173, 32'h173);

        run(1, 1023, 32'h1023);
        run(1, 0, 32'h0);
        run(1, 999, 32'h999);
        run(1, 1000, 32'h1000);

        for (int v = 0; v < 256; v++) run(0, v, to_bcd(v));
        for (int v = 0; v < 1024; v++) run(1, v, to_bcd(v));

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
